audio_note_sequencer: RTL and testbench

//  Parametrised jingle sequencer: on a start request it walks a per-song note table
//  and drives a note code plus a note-valid strobe to the tone generator for a

---
 rtl/audio_note_sequencer.sv | 169 ++++++++++++++++
 tb/tb_audio_note_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_note_sequencer.sv
// Jingle sequencer: walks a per-song note table and presents one note code per
// entry for dur*BEAT_CYCLES cycles, separated by one silent load cycle.
module audio_note_sequencer #(
  parameter int NUM_SONGS   = 8,
  parameter int SEL_W       = 3,
  parameter int MAX_NOTES   = 8,
  parameter int BEAT_CYCLES = 4,
  parameter logic [NUM_SONGS*MAX_NOTES*8-1:0] SONG_TABLE = {
    64'h8181818181818181,  // song 7: empty
    64'h8181812131615161,  // song 6: G F G D C
    64'h8181615161514121,  // song 5: C E F G F G
    64'h8181818181813151,  // song 4: F D
    64'h8181818151213131,  // song 3: D D C F
    64'h8181818181812111,  // song 2: B C
    64'h8181818181818181,  // song 1: empty
    64'h8181818181818181   // song 0: empty
  }
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] song_sel,
  input  logic             loop_en,
  input  logic             abort,
  output logic [3:0]       note_sel,
  output logic             note_valid,
  output logic             busy,
  output logic             seq_end
);

  localparam int BW = $clog2(BEAT_CYCLES + 1);
  localparam int IW = $clog2(MAX_NOTES + 1);

  // Handshake: start and abort are single-cycle requests sampled on every rising
  // edge with no ready; abort beats start, start beats every internal transition.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] song_q, song_d;
  logic             loop_q, loop_d;
  logic [IW-1:0]    index_q, index_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [3:0]       beats_q, beats_d;
  logic [3:0]       note_sel_q, note_sel_d;
  logic             note_valid_q, note_valid_d;
  logic             busy_q, busy_d;
  logic             seq_end_q, seq_end_d;

  logic [7:0] entry;
  logic [3:0] dur_eff;
  logic       at_end;

  // Songs outside the table and reads past the last entry behave as an end code.
  always_comb begin
    entry = 8'h80;
    if (int'(song_q) < NUM_SONGS && int'(index_q) < MAX_NOTES)
      entry = SONG_TABLE[(int'(song_q) * MAX_NOTES + int'(index_q)) * 8 +: 8];
  end

  assign dur_eff = (entry[3:0] == 4'd0) ? 4'd1 : entry[3:0];
  assign at_end  = (entry[7:4] == 4'd8) || (index_q == IW'(MAX_NOTES));

  always_comb begin
    state_d      = state_q;
    song_d       = song_q;
    loop_d       = loop_q;
    index_d      = index_q;
    beat_d       = beat_q;
    beats_d      = beats_q;
    note_sel_d   = note_sel_q;
    note_valid_d = note_valid_q;
    busy_d       = busy_q;
    seq_end_d    = 1'b0;

    if (abort) begin
      state_d      = S_IDLE;
      index_d      = '0;
      beat_d       = '0;
      beats_d      = '0;
      note_sel_d   = 4'd7;
      note_valid_d = 1'b0;
      busy_d       = 1'b0;
    end else if (start) begin
      state_d      = S_LOAD;
      song_d       = song_sel;
      loop_d       = loop_en;
      index_d      = '0;
      beat_d       = '0;
      beats_d      = '0;
      note_sel_d   = 4'd7;
      note_valid_d = 1'b0;
      busy_d       = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          note_sel_d   = 4'd7;
          note_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
        S_LOAD: begin
          if (at_end) begin
            if (loop_q && index_q != '0) begin
              index_d = '0;
            end else begin
              state_d   = S_IDLE;
              index_d   = '0;
              busy_d    = 1'b0;
              seq_end_d = 1'b1;
            end
          end else begin
            state_d      = S_PLAY;
            beat_d       = '0;
            beats_d      = dur_eff - 4'd1;
            note_valid_d = (entry[7:4] <= 4'd6);
            note_sel_d   = (entry[7:4] <= 4'd6) ? entry[7:4] : 4'd7;
          end
        end
        S_PLAY: begin
          if (beat_q == BW'(BEAT_CYCLES - 1)) begin
            beat_d = '0;
            if (beats_q == 4'd0) begin
              state_d      = S_LOAD;
              index_d      = index_q + IW'(1);
              note_sel_d   = 4'd7;
              note_valid_d = 1'b0;
            end else begin
              beats_d = beats_q - 4'd1;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      song_q       <= '0;
      loop_q       <= 1'b0;
      index_q      <= '0;
      beat_q       <= '0;
      beats_q      <= '0;
      note_sel_q   <= 4'd7;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      seq_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      loop_q       <= loop_d;
      index_q      <= index_d;
      beat_q       <= beat_d;
      beats_q      <= beats_d;
      note_sel_q   <= note_sel_d;
      note_valid_q <= note_valid_d;
      busy_q       <= busy_d;
      seq_end_q    <= seq_end_d;
    end
  end

  assign note_sel   = note_sel_q;
  assign note_valid = note_valid_q;
  assign busy       = busy_q;
  assign seq_end    = seq_end_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Bench for audio_note_sequencer: a timeline model predicts every output cycle,
// plus directed literal checks on the documented scenarios.
module tb_audio_note_sequencer;

  localparam int NS = 8;
  localparam int MN = 8;
  localparam int BC = 4;

  // Default table with song 0 replaced by {A,3},{rest,0},end and song 1 by eight
  // entries carrying no end code.
  localparam logic [NS*MN*8-1:0] TB_TABLE = {
    64'h8181818181818181,
    64'h8181812131615161,
    64'h8181615161514121,
    64'h8181818181813151,
    64'h8181818151213131,
    64'h8181818181812111,
    64'h31F1510261409012,
    64'h8181818181817003
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] song_sel = '0;
  logic       loop_en = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] note_sel;
  logic       note_valid;
  logic       busy;
  logic       seq_end;

  audio_note_sequencer #(
    .NUM_SONGS(NS), .SEL_W(3), .MAX_NOTES(MN), .BEAT_CYCLES(BC), .SONG_TABLE(TB_TABLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .song_sel(song_sel), .loop_en(loop_en),
    .abort(abort), .note_sel(note_sel), .note_valid(note_valid), .busy(busy),
    .seq_end(seq_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---- timeline model: each element is {note_sel, note_valid, busy, seq_end} ----
  localparam logic [6:0] IDLE_O = {4'd7, 1'b0, 1'b0, 1'b0};
  localparam logic [6:0] GAP_O  = {4'd7, 1'b0, 1'b1, 1'b0};
  localparam logic [6:0] END_O  = {4'd7, 1'b0, 1'b0, 1'b1};

  logic [6:0] exp_q[$];
  logic [6:0] exp_now = IDLE_O;
  int         cur_song;
  bit         loop_act;

  function automatic logic [7:0] tb_entry(int s, int i);
    if (s >= NS || i >= MN) return 8'h80;
    return TB_TABLE[(s * MN + i) * 8 +: 8];
  endfunction

  // One pass through a song: per entry one silent load cycle then the note for
  // dur beats, plus the load cycle that discovers the end.
  task automatic add_pass(input int s, output int n);
    logic [7:0] e;
    int d;
    n = 0;
    for (int i = 0; i < MN; i++) begin
      e = tb_entry(s, i);
      if (e[7:4] == 4'd8) break;
      d = (e[3:0] == 0) ? 1 : int'(e[3:0]);
      exp_q.push_back(GAP_O);
      for (int k = 0; k < d * BC; k++)
        exp_q.push_back((e[7:4] <= 6) ? {e[7:4], 1'b1, 1'b1, 1'b0} : GAP_O);
      n++;
    end
    exp_q.push_back(GAP_O);
  endtask

  always @(posedge clk) begin
    int n;
    if (reset || abort) begin
      exp_q.delete();
      loop_act = 1'b0;
    end else if (start) begin
      exp_q.delete();
      cur_song = int'(song_sel);
      add_pass(cur_song, n);
      loop_act = loop_en && (n > 0);
      if (!loop_act) exp_q.push_back(END_O);
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0 && loop_act) add_pass(cur_song, n);
    end
    exp_now = (exp_q.size() > 0) ? exp_q[0] : IDLE_O;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({note_sel, note_valid, busy, seq_end} !== exp_now) begin
        errors++;
        $display("FAIL model t=%0t got ns=%0d nv=%b busy=%b se=%b exp ns=%0d nv=%b busy=%b se=%b",
                 $time, note_sel, note_valid, busy, seq_end,
                 exp_now[6:3], exp_now[2], exp_now[1], exp_now[0]);
      end
    end
  end

  // ---- driver tasks ----
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int s, input bit lp);
    song_sel = 3'(s);
    loop_en  = lp;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d exp %0d", nm, $time, got, exp);
    end
  endtask

  initial begin
    int r;
    tick(3);
    reset = 1'b0;
    chk_en = 1'b1;
    lit("reset_ns", 8'(note_sel), 8'd7);
    lit("reset_busy", 8'(busy), 8'd0);

    // song 2: B then C
    pulse_start(2, 1'b0);
    lit("s2_load_busy", 8'(busy), 8'd1);
    lit("s2_load_ns", 8'(note_sel), 8'd7);
    tick(1); lit("s2_b_first", 8'(note_sel), 8'd1); lit("s2_b_nv", 8'(note_valid), 8'd1);
    tick(3); lit("s2_b_last", 8'(note_sel), 8'd1);
    tick(1); lit("s2_gap", 8'(note_sel), 8'd7); lit("s2_gap_nv", 8'(note_valid), 8'd0);
    tick(1); lit("s2_c_first", 8'(note_sel), 8'd2);
    tick(4); lit("s2_endload_se", 8'(seq_end), 8'd0); lit("s2_endload_busy", 8'(busy), 8'd1);
    tick(1); lit("s2_seq_end", 8'(seq_end), 8'd1); lit("s2_end_busy", 8'(busy), 8'd0);
    tick(1); lit("s2_se_pulse", 8'(seq_end), 8'd0);

    // song 0 override: A for 3 beats, rest for 1 beat
    pulse_start(0, 1'b0);
    tick(1);  lit("s0_a_first", 8'(note_sel), 8'd0); lit("s0_a_nv", 8'(note_valid), 8'd1);
    tick(11); lit("s0_a_last", 8'(note_sel), 8'd0);
    tick(1);  lit("s0_gap_busy", 8'(busy), 8'd1);
    tick(1);  lit("s0_rest_ns", 8'(note_sel), 8'd7); lit("s0_rest_nv", 8'(note_valid), 8'd0);
    tick(3);  lit("s0_rest_busy", 8'(busy), 8'd1);
    tick(1);  lit("s0_endload_se", 8'(seq_end), 8'd0);
    tick(1);  lit("s0_seq_end", 8'(seq_end), 8'd1);

    // looping song 4, then abort
    pulse_start(4, 1'b1);
    tick(60); lit("s4_loop_busy", 8'(busy), 8'd1);
    abort = 1'b1; tick(1); abort = 1'b0;
    lit("abort_busy", 8'(busy), 8'd0); lit("abort_ns", 8'(note_sel), 8'd7);
    lit("abort_se", 8'(seq_end), 8'd0);
    tick(1); lit("abort_se2", 8'(seq_end), 8'd0);

    // restart song 6 over song 5, then start+abort
    pulse_start(5, 1'b0);
    tick(7); lit("s5_e", 8'(note_sel), 8'd4);
    pulse_start(6, 1'b0);
    lit("restart_ns", 8'(note_sel), 8'd7); lit("restart_busy", 8'(busy), 8'd1);
    tick(1); lit("restart_g", 8'(note_sel), 8'd6);
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    lit("sa_busy", 8'(busy), 8'd0);
    tick(1); lit("sa_dropped", 8'(busy), 8'd0);

    // empty song with loop, then implicit end after entry 7
    pulse_start(7, 1'b1);
    lit("empty_busy", 8'(busy), 8'd1); lit("empty_se0", 8'(seq_end), 8'd0);
    tick(1); lit("empty_se", 8'(seq_end), 8'd1); lit("empty_idle", 8'(busy), 8'd0);
    pulse_start(1, 1'b0);
    tick(48); lit("impl_busy", 8'(busy), 8'd1); lit("impl_se0", 8'(seq_end), 8'd0);
    tick(1);  lit("impl_se", 8'(seq_end), 8'd1);

    // reset mid-PLAY
    pulse_start(3, 1'b0);
    tick(4);
    reset = 1'b1; tick(1);
    lit("rst_ns", 8'(note_sel), 8'd7); lit("rst_busy", 8'(busy), 8'd0);
    lit("rst_se", 8'(seq_end), 8'd0);
    tick(2); reset = 1'b0; tick(1);
    lit("rst_after", 8'(busy), 8'd0);

    // randomized traffic, checked by the model every cycle
    for (int it = 0; it < 250; it++) begin
      tick($urandom_range(0, 40));
      r = $urandom_range(0, 19);
      if (r < 13) begin
        pulse_start($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end else if (r < 16) begin
        abort = 1'b1; tick(1); abort = 1'b0;
      end else if (r < 18) begin
        song_sel = 3'($urandom_range(0, 7));
        start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
      end else begin
        reset = 1'b1; tick($urandom_range(1, 3)); reset = 1'b0;
      end
    end
    tick(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
